mem_copy_master: RTL and testbench

Bus initiator for the word-addressed data-memory map. It copies a block of words from a source address range to a destination address range using the same single-port interface that the memory responder serves: `address`, `wboolean`, `wdata` and `rdata`. Typical use is loading ROM constants (base 27362) into RAM (0–27359) at boot without CPU involvement. It sits beside the CPU and owns the memory port while `busy` is high.

---
 rtl/mem_copy_master.sv | 135 +++++++++++++
 tb/tb_mem_copy_master.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_copy_master.sv
// mem_copy_master: copies a block of words from src to dst over the single-port memory map.
// Define MEMCOPY_GPIO_DONE_EN to add a completion write of 32'h1 to GPIO_ADDR before done.
module mem_copy_master #(
    parameter int unsigned CNT_W     = 16,
    parameter logic [31:0] GPIO_ADDR = 32'd27361
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [31:0]      address,
    output logic             wboolean,
    output logic [31:0]      wdata,
    input  logic [31:0]      rdata
);

`ifdef MEMCOPY_GPIO_DONE_EN
    typedef enum logic [2:0] {StIdle, StRead, StWrite, StGpio, StDone} state_e;
`else
    typedef enum logic [2:0] {StIdle, StRead, StWrite, StDone} state_e;
    logic unused_gpio_addr;
    assign unused_gpio_addr = ^GPIO_ADDR;
`endif

    state_e           state_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] idx_q;
    logic [CNT_W-1:0] idx_inc;

    assign idx_inc = idx_q + CNT_W'(1);

    // Bus outputs are registered one state ahead; wdata doubles as the read-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            idx_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            address  <= '0;
            wboolean <= 1'b0;
            wdata    <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        src_q <= src_addr;
                        dst_q <= dst_addr;
                        cnt_q <= count;
                        idx_q <= '0;
                        if (count == '0) begin
`ifdef MEMCOPY_GPIO_DONE_EN
                            state_q  <= StGpio;
                            busy     <= 1'b1;
                            address  <= GPIO_ADDR;
                            wdata    <= 32'h1;
                            wboolean <= 1'b1;
`else
                            state_q  <= StDone;
                            done     <= 1'b1;
`endif
                        end else begin
                            state_q  <= StRead;
                            busy     <= 1'b1;
                            address  <= src_addr;
                            wboolean <= 1'b0;
                            wdata    <= '0;
                        end
                    end
                end
                StRead: begin
                    state_q  <= StWrite;
                    address  <= dst_q + 32'(idx_q);
                    wdata    <= rdata;
                    wboolean <= 1'b1;
                end
                StWrite: begin
                    idx_q <= idx_inc;
                    if (idx_inc == cnt_q) begin
`ifdef MEMCOPY_GPIO_DONE_EN
                        state_q  <= StGpio;
                        address  <= GPIO_ADDR;
                        wdata    <= 32'h1;
                        wboolean <= 1'b1;
`else
                        state_q  <= StDone;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        address  <= '0;
                        wdata    <= '0;
                        wboolean <= 1'b0;
`endif
                    end else begin
                        state_q  <= StRead;
                        address  <= src_q + 32'(idx_inc);
                        wdata    <= '0;
                        wboolean <= 1'b0;
                    end
                end
`ifdef MEMCOPY_GPIO_DONE_EN
                StGpio: begin
                    state_q  <= StDone;
                    busy     <= 1'b0;
                    done     <= 1'b1;
                    address  <= '0;
                    wdata    <= '0;
                    wboolean <= 1'b0;
                end
`endif
                StDone: begin
                    state_q <= StIdle;
                    done    <= 1'b0;
                end
                default: begin
                    state_q  <= StIdle;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    address  <= '0;
                    wdata    <= '0;
                    wboolean <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_copy_master.sv
// Self-checking bench for mem_copy_master: memory model with a small ROM and RAM window,
// expected contents derived from a pre-copy snapshot.
module tb_mem_copy_master;

    localparam logic [31:0] ROM_BASE = 32'd27362;
`ifdef MEMCOPY_GPIO_DONE_EN
    localparam int GX = 1;
`else
    localparam int GX = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic [31:0] address;
    logic        wboolean;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic [31:0] rom  [16];
    logic [31:0] ram  [256];
    logic [31:0] snap [256];
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    logic [31:0] rd_addr [$];
    logic        init_req;

    int n_asrt = 0;
    int n_fail = 0;

    mem_copy_master #(.CNT_W(16), .GPIO_ADDR(32'd27361)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .address  (address),
        .wboolean (wboolean),
        .wdata    (wdata),
        .rdata    (rdata)
    );

    always #5 clk = ~clk;

    always_comb begin
        rdata = 32'h0;
        if (address >= ROM_BASE && address < ROM_BASE + 32'd16)
            rdata = rom[4'(address - ROM_BASE)];
        else if (address < 32'd256)
            rdata = ram[address[7:0]];
    end

    // Memory responder plus bus activity log.
    always @(posedge clk) begin
        if (init_req) begin
            for (int a = 0; a < 256; a++) ram[a] = $urandom;
        end
        if (rst_n && wboolean) begin
            wr_addr.push_back(address);
            wr_data.push_back(wdata);
            if (address < 32'd256) ram[address[7:0]] = wdata;
        end
        if (rst_n && busy && !wboolean) rd_addr.push_back(address);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        if (a >= ROM_BASE && a < ROM_BASE + 32'd16) return rom[4'(a - ROM_BASE)];
        if (a < 32'd256) return snap[a[7:0]];
        return 32'h0;
    endfunction

    // Number of RAM words differing from "snapshot with n words copied src->dst".
    function automatic int ram_bad(input logic [31:0] s, input logic [31:0] d, input int n,
                                   input int skip);
        int bad = 0;
        for (int a = 0; a < 256; a++) begin
            logic [31:0] off;
            logic [31:0] exp;
            off = 32'(a) - d;
            exp = (off < 32'(n)) ? ref_rd(s + off) : snap[a];
            if (a != skip && ram[a] !== exp) bad++;
        end
        return bad;
    endfunction

    task automatic run_copy(input logic [31:0] s, input logic [31:0] d, input int n,
                            input int pulse_at, output int done_cyc, output int busy_cyc);
        wr_addr.delete();
        wr_data.delete();
        rd_addr.delete();
        for (int a = 0; a < 256; a++) snap[a] = ram[a];
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        count    = 16'(n);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        done_cyc = -1;
        busy_cyc = 0;
        for (int c = 1; c <= 200; c++) begin
            if (done === 1'b1) begin
                done_cyc = c;
                break;
            end
            if (busy === 1'b1) busy_cyc++;
            if (c == pulse_at) begin
                start    = 1'b1;
                src_addr = s + 32'd7;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        chk("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int dc, bc, idle_busy, seen_done;
        logic [31:0] s, d;
        int n;

        rst_n    = 1'b0;
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        count    = '0;
        init_req = 1'b1;
        for (int k = 0; k < 16; k++) rom[k] = $urandom;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_address", address, 32'd0);
        chk("rst_wboolean", 32'(wboolean), 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        @(posedge clk);
        #1;
        init_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Basic ROM -> RAM copy of four words.
        run_copy(ROM_BASE, 32'd100, 4, 0, dc, bc);
        chk("basic_done_cycle", 32'(dc), 32'(9 + GX));
        chk("basic_busy_cycles", 32'(bc), 32'(8 + GX));
        chk("basic_writes", 32'(wr_addr.size()), 32'(4 + GX));
        chk("basic_ram", 32'(ram_bad(ROM_BASE, 32'd100, 4, -1)), 32'd0);
        chk("basic_ram103", ram[103], rom[3]);

        // Zero count: immediate done, no bus traffic.
        run_copy(ROM_BASE, 32'd50, 0, 0, dc, bc);
        chk("zero_done_cycle", 32'(dc), 32'(1 + GX));
        chk("zero_writes", 32'(wr_addr.size()), 32'(GX));
        chk("zero_reads", 32'(rd_addr.size()), 32'd0);
        chk("zero_ram", 32'(ram_bad(ROM_BASE, 32'd50, 0, -1)), 32'd0);

        // Start pulsed while busy must be ignored.
        run_copy(ROM_BASE + 32'd4, 32'd200, 3, 2, dc, bc);
        chk("busy_start_done_cycle", 32'(dc), 32'(7 + GX));
        chk("busy_start_writes", 32'(wr_addr.size()), 32'(3 + GX));
        chk("busy_start_ram", 32'(ram_bad(ROM_BASE + 32'd4, 32'd200, 3, -1)), 32'd0);
        idle_busy = 0;
        seen_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b0) idle_busy++;
            if (done !== 1'b0) seen_done++;
        end
        chk("busy_start_no_rerun", 32'(idle_busy), 32'd0);
        chk("busy_start_one_done", 32'(seen_done), 32'd0);

        // Randomized RAM -> RAM copies, non-overlapping windows.
        for (int t = 0; t < 4; t++) begin
            s = 32'($urandom_range(0, 63));
            d = 32'($urandom_range(128, 191));
            n = int'($urandom_range(1, 40));
            run_copy(s, d, n, 0, dc, bc);
            chk("rand_done_cycle", 32'(dc), 32'(2 * n + 1 + GX));
            chk("rand_writes", 32'(wr_addr.size()), 32'(n + GX));
            chk("rand_ram", 32'(ram_bad(s, d, n, -1)), 32'd0);
        end

        // Address wrap at the top of the 32-bit map.
        run_copy(32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 0, dc, bc);
        chk("wrap_done_cycle", 32'(dc), 32'(5 + GX));
        chk("wrap_reads", 32'(rd_addr.size()), 32'd2);
        if (rd_addr.size() == 2) begin
            chk("wrap_rd0", rd_addr[0], 32'hFFFF_FFFF);
            chk("wrap_rd1", rd_addr[1], 32'h0000_0000);
        end
        chk("wrap_writes", 32'(wr_addr.size()), 32'(2 + GX));
        if (wr_addr.size() >= 2) begin
            chk("wrap_wa0", wr_addr[0], 32'hFFFF_FFFE);
            chk("wrap_wa1", wr_addr[1], 32'hFFFF_FFFF);
            chk("wrap_wd0", wr_data[0], 32'h0);
            chk("wrap_wd1", wr_data[1], snap[0]);
        end

`ifdef MEMCOPY_GPIO_DONE_EN
        // Single-word copy followed by the completion write.
        run_copy(ROM_BASE, 32'd10, 1, 0, dc, bc);
        chk("gpio_done_cycle", 32'(dc), 32'd4);
        chk("gpio_writes", 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            chk("gpio_addr", wr_addr[1], 32'd27361);
            chk("gpio_data", wr_data[1], 32'h1);
        end
`endif

        // Asynchronous reset during the third WRITE cycle.
        for (int a = 0; a < 256; a++) snap[a] = ram[a];
        @(negedge clk);
        src_addr = ROM_BASE;
        dst_addr = 32'd160;
        count    = 16'd8;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("rst_mid_in_write", 32'(wboolean), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wboolean", 32'(wboolean), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_address", address, 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done !== 1'b0) seen_done++;
        end
        chk("rst_mid_no_done", 32'(seen_done), 32'd0);
        chk("rst_mid_ram", 32'(ram_bad(ROM_BASE, 32'd160, 2, 162)), 32'd0);
        n_asrt++;
        assert (ram[162] === snap[162] || ram[162] === rom[2]) else begin
            n_fail++;
            $error("FAIL rst_mid_ram162: observed %h expected %h or %h",
                   ram[162], snap[162], rom[2]);
        end

        // Normal operation after the aborted copy.
        run_copy(ROM_BASE + 32'd8, 32'd20, 5, 0, dc, bc);
        chk("post_rst_done_cycle", 32'(dc), 32'(11 + GX));
        chk("post_rst_ram", 32'(ram_bad(ROM_BASE + 32'd8, 32'd20, 5, -1)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
